// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: receive-path state type and RMII dibit constants
package eth_rx_pkg;
   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} rx_state_t;
   localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
   localparam logic [1:0] SFD_DIBIT = 2'b11;
   localparam int DIBITS_PER_BYTE = 4;
endpackage

// File: rtl/buffer_ra.sv
// buffer_ra: shift buffer of INPUT_SIZE-bit words, entering at the MSB when REVERSE is set
module buffer_ra #(
   parameter int BUFFER_SIZE = 8,
   parameter int INPUT_SIZE = 2,
   parameter bit REVERSE = 1'b0
) (
   input  logic                   clk_in,
   input  logic                   rst,
   input  logic                   trigger,
   input  logic [INPUT_SIZE-1:0]  data_in,
   output logic [BUFFER_SIZE-1:0] data_out
);
   always_ff @(posedge clk_in)
      if (rst) data_out <= '0;
      else if (trigger) data_out <= REVERSE ? {data_in, data_out[BUFFER_SIZE-1:INPUT_SIZE]}
                                            : {data_out[BUFFER_SIZE-INPUT_SIZE-1:0], data_in};
endmodule

// File: rtl/eth_rmii_rx_sequencer.sv
// eth_rmii_rx_sequencer: RMII preamble/SFD detection and byte framing toward the MAC parser
module eth_rmii_rx_sequencer
   import eth_rx_pkg::*;
#(
   parameter int MAX_FRAME_BYTES = 1522,
   parameter int MIN_PREAMBLE_DIBITS = 8,
   parameter int BYTE_COUNT_WIDTH = 11
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        sample_en_in,
   input  logic                        crsdv_in,
   input  logic [1:0]                  rxd_in,
   output logic [7:0]                  byte_out,
   output logic                        byte_valid_out,
   output logic                        frame_start_out,
   output logic                        frame_end_out,
   output logic                        error_out,
   output logic [BYTE_COUNT_WIDTH-1:0] byte_count_out
);
   localparam logic [BYTE_COUNT_WIDTH-1:0] MAX_CNT = BYTE_COUNT_WIDTH'(MAX_FRAME_BYTES);
   rx_state_t state;
   logic [4:0] pre_cnt;
   logic [1:0] dibit_cnt;
   logic first, byte_pend, end_pend, err_pend, sfd_accept, trigger, end_err;
   logic [7:0] buf_data;
   logic [BYTE_COUNT_WIDTH-1:0] cnt_next;
   assign sfd_accept = sample_en_in & crsdv_in & (state == PREAMBLE) & (rxd_in == SFD_DIBIT)
                       & (int'(pre_cnt) >= MIN_PREAMBLE_DIBITS);
   assign trigger = (state == DATA) & crsdv_in & sample_en_in;
   // a byte still awaiting its strobe already counts toward the frame length
   assign cnt_next = byte_count_out + BYTE_COUNT_WIDTH'(byte_pend);
   assign end_err = (dibit_cnt != 2'd0) || (cnt_next == '0) || (cnt_next == MAX_CNT);
   buffer_ra #(.BUFFER_SIZE(8), .INPUT_SIZE(2), .REVERSE(1'b1)) u_buf (
      .clk_in(clk_in),
      .rst(!rst_in | sfd_accept),
      .trigger(trigger),
      .data_in(rxd_in),
      .data_out(buf_data)
   );
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state <= IDLE;
         pre_cnt <= '0;
         dibit_cnt <= '0;
         first <= 1'b0;
         byte_pend <= 1'b0;
         end_pend <= 1'b0;
         err_pend <= 1'b0;
         byte_out <= '0;
         byte_valid_out <= 1'b0;
         frame_start_out <= 1'b0;
         frame_end_out <= 1'b0;
         error_out <= 1'b0;
         byte_count_out <= '0;
      end else begin
         byte_valid_out <= 1'b0;
         frame_start_out <= 1'b0;
         frame_end_out <= 1'b0;
         error_out <= 1'b0;
         if (sample_en_in) begin
            if (byte_pend) begin
               byte_valid_out <= 1'b1;
               frame_start_out <= first;
               first <= 1'b0;
               byte_out <= buf_data;
               byte_count_out <= byte_count_out + BYTE_COUNT_WIDTH'(1);
               byte_pend <= 1'b0;
            end
            if (end_pend) begin
               frame_end_out <= 1'b1;
               error_out <= err_pend;
               end_pend <= 1'b0;
            end
            case (state)
               IDLE: if (crsdv_in && rxd_in == PREAMBLE_DIBIT) begin
                  state <= PREAMBLE;
                  pre_cnt <= 5'd1;
               end
               PREAMBLE:
                  if (!crsdv_in) state <= IDLE;
                  else if (rxd_in == PREAMBLE_DIBIT) pre_cnt <= pre_cnt == 5'd31 ? pre_cnt : pre_cnt + 5'd1;
                  else if (sfd_accept) begin
                     state <= DATA;
                     dibit_cnt <= '0;
                     byte_count_out <= '0;
                     first <= 1'b1;
                  end else state <= DROP;
               DATA:
                  if (byte_count_out == MAX_CNT) begin
                     frame_end_out <= 1'b1;
                     error_out <= 1'b1;
                     state <= DROP;
                  end else if (!crsdv_in) begin
                     // end strobe waits one enabled cycle if the final byte is being emitted now
                     state <= IDLE;
                     end_pend <= byte_pend;
                     err_pend <= end_err;
                     frame_end_out <= !byte_pend;
                     error_out <= !byte_pend & end_err;
                  end else begin
                     dibit_cnt <= dibit_cnt + 2'd1;
                     if (dibit_cnt == 2'(DIBITS_PER_BYTE - 1)) byte_pend <= 1'b1;
                  end
               default: if (!crsdv_in) state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_eth_rmii_rx_sequencer.sv
// tb_eth_rmii_rx_sequencer: directed and randomized RMII frames scored against a frame-level model
module tb_eth_rmii_rx_sequencer;
   localparam int MAX = 4;
   localparam int MIN = 8;
   typedef struct {
      bit is_end;
      logic [7:0] data;
      bit start;
      bit err;
      int cnt;
   } ev_t;
   logic clk_in = 1'b0, rst_in = 1'b0, sample_en_in = 1'b0, crsdv_in = 1'b0;
   logic [1:0] rxd_in = 2'b00;
   logic [7:0] byte_out;
   logic byte_valid_out, frame_start_out, frame_end_out, error_out;
   logic [10:0] byte_count_out;
   ev_t q[$];
   ev_t e;
   logic [7:0] pl[$];
   int checks = 0, errors = 0, mode = 0, last_cnt = 0;
   int pre, nb, bad;

   eth_rmii_rx_sequencer #(.MAX_FRAME_BYTES(MAX), .MIN_PREAMBLE_DIBITS(MIN)) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .sample_en_in(sample_en_in),
      .crsdv_in(crsdv_in),
      .rxd_in(rxd_in),
      .byte_out(byte_out),
      .byte_valid_out(byte_valid_out),
      .frame_start_out(frame_start_out),
      .frame_end_out(frame_end_out),
      .error_out(error_out),
      .byte_count_out(byte_count_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic void check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   always @(negedge clk_in) if (rst_in) begin
      if (byte_valid_out || frame_end_out) begin
         check("strobe_overlap", int'(byte_valid_out & frame_end_out), 0);
         check("strobe_expected", int'(q.size() > 0), 1);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("event_kind", int'(frame_end_out), int'(e.is_end));
            check("byte_count", int'(byte_count_out), e.cnt);
            if (e.is_end) begin
               check("error_out", int'(error_out), int'(e.err));
               check("start_on_end", int'(frame_start_out), 0);
            end else begin
               check("byte_out", int'(byte_out), int'(e.data));
               check("frame_start", int'(frame_start_out), int'(e.start));
               check("error_on_byte", int'(error_out), 0);
            end
         end
      end else check("idle_strobes", int'({frame_start_out, error_out}), 0);
   end

   task automatic send(input logic c, input logic [1:0] d);
      int gap = mode == 0 ? 0 : mode == 1 ? 1 : int'($urandom_range(0, 2));
      repeat (gap) begin
         @(negedge clk_in);
         sample_en_in = 1'b0;
      end
      @(negedge clk_in);
      sample_en_in = 1'b1;
      crsdv_in = c;
      rxd_in = d;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 0; i < 4; i++) send(1'b1, b[2*i +: 2]);
   endtask

   // model: a frame is accepted only with >= MIN clean preamble dibits; bytes are capped at MAX
   task automatic frame(input int npre, input int bad_at, input int extra);
      bit ok = npre >= MIN && bad_at < 0;
      int n = pl.size() < MAX ? pl.size() : MAX;
      logic [1:0] bd = $urandom_range(0, 1) ? 2'b10 : 2'b00;
      if (ok) begin
         for (int i = 0; i < n; i++) q.push_back('{1'b0, pl[i], i == 0, 1'b0, i + 1});
         q.push_back('{1'b1, 8'h00, 1'b0, pl.size() >= MAX || pl.size() == 0 || extra != 0, n});
         last_cnt = n;
      end
      repeat ($urandom_range(0, 2)) send(1'b1, 2'b00);
      for (int i = 0; i < npre; i++) send(1'b1, i == bad_at ? bd : 2'b01);
      send(1'b1, 2'b11);
      foreach (pl[i]) send_byte(pl[i]);
      repeat (extra) send(1'b1, 2'($urandom));
      repeat (3) send(1'b0, 2'b00);
      check("count_hold", int'(byte_count_out), last_cnt);
   endtask

   initial begin
      repeat (3) @(negedge clk_in);
      check("rst_byte_out", int'(byte_out), 0);
      check("rst_count", int'(byte_count_out), 0);
      check("rst_strobes", int'({byte_valid_out, frame_start_out, frame_end_out, error_out}), 0);
      rst_in = 1'b1;
      mode = 0;
      pl = '{8'hA5, 8'h3C, 8'hFF};
      frame(28, -1, 0);
      mode = 1;
      pl = '{8'h12};
      frame(10, -1, 0);
      mode = 0;
      pl = '{8'h77, 8'h88};
      frame(4, -1, 0);
      pl = '{8'h0F};
      frame(10, -1, 2);
      pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      frame(12, -1, 0);
      mode = 2;
      pl = '{8'h81, 8'h7E};
      for (int i = 0; i < 2; i++) q.push_back('{1'b0, pl[i], i == 0, 1'b0, i + 1});
      repeat (10) send(1'b1, 2'b01);
      send(1'b1, 2'b11);
      foreach (pl[i]) send_byte(pl[i]);
      send(1'b1, 2'b10);
      send(1'b1, 2'b01);
      @(negedge clk_in);
      rst_in = 1'b0;
      crsdv_in = 1'b0;
      sample_en_in = 1'b1;
      @(negedge clk_in);
      check("midrst_byte_out", int'(byte_out), 0);
      check("midrst_count", int'(byte_count_out), 0);
      check("midrst_strobes", int'({byte_valid_out, frame_start_out, frame_end_out, error_out}), 0);
      rst_in = 1'b1;
      last_cnt = 0;
      repeat (2) send(1'b0, 2'b00);
      mode = 0;
      pl = '{8'hC3};
      frame(12, -1, 0);
      for (int f = 0; f < 40; f++) begin
         pre = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 7)) : int'($urandom_range(8, 40));
         nb = $urandom_range(0, 6);
         bad = (pre >= 3 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, pre - 1)) : -1;
         mode = $urandom_range(0, 2);
         pl.delete();
         repeat (nb) pl.push_back(8'($urandom));
         frame(pre, bad, $urandom_range(0, 3));
      end
      repeat (10) send(1'b0, 2'b00);
      check("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/eth_rmii_rx_sequencer.md
Name: eth_rmii_rx_sequencer

Overview:
Receive-side controller for the RMII interface. It samples 2-bit RMII dibits and detects preamble and SFD. It sequences a dibit-to-byte shift buffer by driving its trigger and reset, then emits framed bytes with start, end and error strobes to the MAC parser. It sits between the RMII pins (already synchronised) and the frame/CRC logic.

Parameters:
MAX_FRAME_BYTES, 1522, byte count at which the frame is aborted with error
MIN_PREAMBLE_DIBITS, 8, minimum count of 2'b01 dibits before SFD is accepted
BYTE_COUNT_WIDTH, 11, width of byte_count_out

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous, active-low reset
sample_en_in  input  1  RMII sample strobe; all state advances only when high
crsdv_in  input  1  RMII carrier-sense/data-valid
rxd_in  input  2  RMII receive dibit, LSB-first within byte
byte_out  output  8  assembled byte, valid only while byte_valid_out high
byte_valid_out  output  1  one-cycle strobe per received byte
frame_start_out  output  1  high with the first byte_valid_out of a frame
frame_end_out  output  1  one-cycle strobe at end of an accepted frame
error_out  output  1  one-cycle strobe coincident with frame_end_out on a bad frame
byte_count_out  output  BYTE_COUNT_WIDTH  bytes in current/last frame; holds after end

Behaviour:
- Reset (rst_in low at clk edge): state IDLE. All strobes 0, byte_out 0, byte_count_out 0, shift buffer cleared, preamble and dibit counters 0. Reset mid-frame drops the frame silently with no frame_end_out.
- sample_en_in low: no state, counter or buffer change. All strobes are forced 0 that cycle; strobes are single clk_in cycles.
- IDLE: crsdv_in=1 and rxd_in=01 -> PREAMBLE, pre_cnt=1. Any other input stays in IDLE (false carrier rxd=00 tolerated).
- PREAMBLE:
  - crsdv_in=0 -> IDLE.
  - rxd=01 -> pre_cnt+1, saturating at 31.
  - rxd=11 with pre_cnt>=MIN_PREAMBLE_DIBITS -> DATA: clear buffer, dibit_cnt=0, byte_count_out=0, first-byte flag set.
  - rxd=11 with pre_cnt<MIN_PREAMBLE_DIBITS -> DROP.
  - rxd=00 or 10 -> DROP.
- DATA, crsdv_in=1:
  - Trigger the buffer with rxd_in, which shifts in at the MSB so the first dibit ends in bits[1:0]. dibit_cnt increments mod 4.
  - On the 4th dibit: next clk_in cycle byte_valid_out=1 and byte_out=assembled byte, with frame_start_out=1 if the first-byte flag is set (flag then cleared). byte_count_out increments in that same cycle.
  - Latency is 1 clk_in after the enabled edge sampling the 4th dibit.
- DATA, byte_count_out reaching MAX_FRAME_BYTES on a byte: that byte is still emitted. Next enabled cycle frame_end_out=1 and error_out=1, then -> DROP.
- DATA, crsdv_in=0:
  - Next cycle frame_end_out=1, state -> IDLE.
  - error_out=1 if dibit_cnt!=0 (misaligned; the partial byte is discarded) or if byte_count_out==0.
- DROP: ignore data. crsdv_in=0 -> IDLE. No strobes are emitted.
- byte_valid_out and frame_end_out are never high in the same cycle. frame_end_out follows the last byte_valid_out by at least 1 cycle.
- byte_count_out holds its value after frame end until the next SFD clears it.

Decomposition:
- Package eth_rx_pkg holds:
  - state enum rx_state_t {IDLE, PREAMBLE, DATA, DROP}
  - constants PREAMBLE_DIBIT=2'b01, SFD_DIBIT=2'b11, DIBITS_PER_BYTE=4
- Sub-module: the existing buffer_ra with BUFFER_SIZE=8, INPUT_SIZE=2, REVERSE=1.
  - Its active-high reset is driven by (!rst_in | sfd_accept).
  - Its trigger is driven by (state==DATA & crsdv_in & sample_en_in).
  - byte_out is registered from its data_out.

Test Plan:
- 28x dibit 01, dibit 11, then bytes 0x55,0xD5... replaced by payload 0xA5,0x3C,0xFF, then crsdv_in=0 -> byte_out A5/3C/FF with frame_start_out on A5, frame_end_out with error_out=0, byte_count_out=3.
- sample_en_in high every 2nd cycle (50 MHz RMII on 100 MHz clk), payload 0x12 -> one byte_valid_out 0x12, no duplicate strobes, identical count.
- 4x dibit 01 then dibit 11 (MIN=8) followed by data -> DROP, no strobes at all, byte_count_out unchanged from previous frame.
- Valid preamble/SFD, 1 byte 0x0F plus 2 extra dibits, then crsdv_in=0 -> byte 0x0F emitted, frame_end_out=1 with error_out=1, byte_count_out=1.
- MAX_FRAME_BYTES=4, send 6 bytes -> 4 byte_valid_out strobes, frame_end_out+error_out 1 cycle after 4th byte's strobe, remaining bytes ignored until crsdv_in=0.
- rst_in low for 1 cycle mid-DATA after 2 bytes -> all outputs 0, no frame_end_out. The next clean frame decodes correctly.
